// File: rtl/f1_reaction_timer_if.sv
// rtl/f1_reaction_timer_if.sv - light bus, button and result signals of the F1 reaction timer
interface f1_reaction_timer_if;
    logic [7:0]  lights;
    logic        react;
    logic [15:0] rt_bcd;
    logic        valid;
    logic        jump_start;
    logic        timing;
    logic [15:0] best_bcd;

    modport master (
        output lights, react,
        input  rt_bcd, valid, jump_start, timing, best_bcd
    );

    modport slave (
        input  lights, react,
        output rt_bcd, valid, jump_start, timing, best_bcd
    );
endinterface

// File: rtl/f1_reaction_timer.sv
// rtl/f1_reaction_timer.sv - times lights-out to button press in BCD ms, flags jump starts
// Optional best-time tracking is built when F1_BEST_TIME_EN is defined.
module f1_reaction_timer #(
    parameter int CLK_PER_MS  = 1000,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    f1_reaction_timer_if.slave bus
);
    localparam int PW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;

    typedef enum logic [2:0] {IDLE, ARMED, FULL, TIMING, DONE, FAULT} state_t;

    state_t                 state_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_prev_q;
    logic                   press_q;
    logic [PW-1:0]          presc_q, presc_d;
    logic [15:0]            rt_q, rt_d;
    logic                   seen_zero_q;
    logic                   wrap;
    logic                   lights_zero;

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (c) begin
                if (r[i*4 +: 4] == 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Edge detect after the synchroniser so a held button yields one pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q      <= '0;
            sync_prev_q <= 1'b0;
            press_q     <= 1'b0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], bus.react};
            sync_prev_q <= sync_q[SYNC_STAGES-1];
            press_q     <= sync_q[SYNC_STAGES-1] & ~sync_prev_q;
        end
    end

    always_comb begin
        lights_zero = (bus.lights == 8'h00);
        wrap        = (presc_q == PW'(CLK_PER_MS - 1));
        presc_d     = wrap ? '0 : presc_q + 1'b1;
        rt_d        = wrap ? bcd_inc(rt_q) : rt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            presc_q     <= '0;
            rt_q        <= 16'h0000;
            seen_zero_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!lights_zero) begin
                        state_q <= ARMED;
                        rt_q    <= 16'h0000;
                    end
                end
                ARMED: begin
                    if (press_q) begin
                        state_q     <= FAULT;
                        rt_q        <= 16'h0000;
                        seen_zero_q <= lights_zero;
                    end else if (bus.lights == 8'hFF) begin
                        state_q <= FULL;
                    end else if (lights_zero) begin
                        state_q <= IDLE;
                    end
                end
                FULL: begin
                    if (press_q) begin
                        state_q     <= FAULT;
                        rt_q        <= 16'h0000;
                        seen_zero_q <= lights_zero;
                    end else if (lights_zero) begin
                        state_q <= TIMING;
                        presc_q <= '0;
                        rt_q    <= 16'h0000;
                    end
                end
                TIMING: begin
                    presc_q <= presc_d;
                    rt_q    <= rt_d;
                    if (press_q || rt_d == 16'h9999) begin
                        state_q <= DONE;
                    end else if (!lights_zero) begin
                        state_q <= ARMED;
                        rt_q    <= 16'h0000;
                    end
                end
                DONE: begin
                    if (!lights_zero) begin
                        state_q <= ARMED;
                        rt_q    <= 16'h0000;
                    end
                end
                FAULT: begin
                    // Only a fresh sequence (lights back to 0 first) may re-arm.
                    if (lights_zero) begin
                        seen_zero_q <= 1'b1;
                    end else if (seen_zero_q) begin
                        state_q <= ARMED;
                        rt_q    <= 16'h0000;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef F1_BEST_TIME_EN
    logic [15:0] best_q;

    // Packed BCD with digits 0..9 orders the same as a plain unsigned compare.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            best_q <= 16'h0000;
        end else if (state_q == TIMING && press_q) begin
            if (best_q == 16'h0000 || rt_d < best_q) begin
                best_q <= rt_d;
            end
        end
    end

    assign bus.best_bcd = best_q;
`else
    assign bus.best_bcd = 16'h0000;
`endif

    assign bus.rt_bcd     = rt_q;
    assign bus.valid      = (state_q == DONE);
    assign bus.jump_start = (state_q == FAULT);
    assign bus.timing     = (state_q == TIMING);
endmodule

// File: tb/tb_f1_reaction_timer.sv
// tb/tb_f1_reaction_timer.sv - scoreboard bench for f1_reaction_timer
module tb_f1_reaction_timer;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    typedef struct packed {
        logic [15:0] rt;
        logic        valid;
        logic        jump;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;

    f1_reaction_timer_if bus ();

    f1_reaction_timer #(.CLK_PER_MS(4), .SYNC_STAGES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic fill();
        logic [7:0] v;
        v = 8'h00;
        for (int i = 0; i < 8; i++) begin
            v = {v[6:0], 1'b1};
            bus.lights = v;
            step(1);
        end
    endtask

    task automatic wait_out(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (bus.valid || bus.jump_start) begin
                ok = 1'b1;
                break;
            end
            step(1);
        end
    endtask

    // ms==0 means never press (saturation run).
    task automatic do_run(input int ms, output bit ok);
        fill();
        step(2);
        bus.lights = 8'h00;
        step(1);
        checks++;
        if (bus.timing !== 1'b1) begin
            errors++;
            $display("FAIL timing_latency got %b want 1", bus.timing);
        end
        if (ms > 0) begin
            step(4 * ms - 3);
            bus.react = 1'b1;
        end
        wait_out((ms > 0) ? 20 : 4 * 9999 + 50, ok);
        bus.react = 1'b0;
        step(4);
    endtask

    task automatic test_reset();
        fill();
        bus.lights = 8'h00;
        step(10);
        checks++;
        if (bus.timing !== 1'b1) begin errors++; $display("FAIL pre_reset_timing got %b want 1", bus.timing); end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.rt_bcd !== 16'h0000) begin errors++; $display("FAIL reset_rt got %h want 0000", bus.rt_bcd); end
        checks++;
        if ({bus.valid, bus.jump_start, bus.timing} !== 3'b000) begin
            errors++; $display("FAIL reset_flags got %b want 000", {bus.valid, bus.jump_start, bus.timing});
        end
        checks++;
        if (bus.best_bcd !== 16'h0000) begin errors++; $display("FAIL reset_best got %h want 0000", bus.best_bcd); end
        @(posedge clk);
        #1 rst = 1'b0;
        step(2);
    endtask

    task automatic test_normal();
        bit ok;
        exp_q.push_back('{rt: 16'h0123, valid: 1'b1, jump: 1'b0});
        do_run(123, ok);
        e = exp_q.pop_front();
        checks++;
        if (!ok) begin errors++; $display("FAIL normal_timeout no result"); end
        checks++;
        if (bus.rt_bcd !== e.rt) begin errors++; $display("FAIL normal_rt got %h want %h", bus.rt_bcd, e.rt); end
        checks++;
        if ({bus.valid, bus.jump_start, bus.timing} !== {e.valid, e.jump, 1'b0}) begin
            errors++; $display("FAIL normal_flags got %b want %b", {bus.valid, bus.jump_start, bus.timing}, {e.valid, e.jump, 1'b0});
        end
        step(20);
        checks++;
        if (bus.rt_bcd !== e.rt || bus.valid !== 1'b1) begin
            errors++; $display("FAIL normal_hold got %h/%b want %h/1", bus.rt_bcd, bus.valid, e.rt);
        end
        bus.lights = 8'h01;
        step(1);
        checks++;
        if (bus.valid !== 1'b0 || bus.rt_bcd !== 16'h0000) begin
            errors++; $display("FAIL normal_rearm got %h/%b want 0000/0", bus.rt_bcd, bus.valid);
        end
        bus.lights = 8'h00;
        step(1);
    endtask

    task automatic test_jump_start();
        bit ok;
        logic [7:0] v;
        v = 8'h00;
        for (int i = 0; i < 5; i++) begin
            v = {v[6:0], 1'b1};
            bus.lights = v;
            step(1);
        end
        bus.react = 1'b1;
        exp_q.push_back('{rt: 16'h0000, valid: 1'b0, jump: 1'b1});
        wait_out(10, ok);
        e = exp_q.pop_front();
        checks++;
        if (!ok) begin errors++; $display("FAIL jump_timeout no result"); end
        checks++;
        if ({bus.rt_bcd, bus.valid, bus.jump_start} !== {e.rt, e.valid, e.jump}) begin
            errors++; $display("FAIL jump_result got %h/%b/%b want %h/%b/%b",
                               bus.rt_bcd, bus.valid, bus.jump_start, e.rt, e.valid, e.jump);
        end
        bus.react = 1'b0;
        step(4);
        checks++;
        if (bus.jump_start !== 1'b1) begin errors++; $display("FAIL jump_hold_lit got %b want 1", bus.jump_start); end
        bus.lights = 8'h00;
        step(1);
        checks++;
        if (bus.jump_start !== 1'b1) begin errors++; $display("FAIL jump_hold_dark got %b want 1", bus.jump_start); end
        bus.lights = 8'h01;
        step(1);
        checks++;
        if (bus.jump_start !== 1'b0 || bus.valid !== 1'b0) begin
            errors++; $display("FAIL jump_rearm got %b/%b want 0/0", bus.jump_start, bus.valid);
        end
        bus.lights = 8'h00;
        step(1);
    endtask

    task automatic test_abort_held();
        bus.lights = 8'h01; step(1);
        bus.lights = 8'h03; step(1);
        bus.lights = 8'h07; step(1);
        bus.lights = 8'h00;
        step(2);
        checks++;
        if ({bus.valid, bus.jump_start, bus.timing} !== 3'b000) begin
            errors++; $display("FAIL abort_flags got %b want 000", {bus.valid, bus.jump_start, bus.timing});
        end
        bus.react = 1'b1;
        step(5);
        fill();
        step(2);
        bus.lights = 8'h00;
        step(41);
        checks++;
        if ({bus.valid, bus.jump_start, bus.timing} !== 3'b001) begin
            errors++; $display("FAIL held_timing got %b want 001", {bus.valid, bus.jump_start, bus.timing});
        end
        bus.lights = 8'h01;
        step(1);
        checks++;
        if ({bus.valid, bus.timing, bus.rt_bcd} !== 18'h0) begin
            errors++; $display("FAIL timing_abort got %b/%b/%h want 0/0/0000", bus.valid, bus.timing, bus.rt_bcd);
        end
        bus.lights = 8'h00;
        bus.react  = 1'b0;
        step(4);
    endtask

    task automatic test_best_time();
        bit ok;
        int          ms_tab[3]   = '{250, 180, 300};
        logic [15:0] rt_tab[3]   = '{16'h0250, 16'h0180, 16'h0300};
        logic [15:0] best_tab[3] = '{16'h0250, 16'h0180, 16'h0180};
        logic [15:0] want_best;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back('{rt: rt_tab[i], valid: 1'b1, jump: 1'b0});
            do_run(ms_tab[i], ok);
            e = exp_q.pop_front();
            checks++;
            if (!ok || bus.rt_bcd !== e.rt || bus.valid !== e.valid) begin
                errors++; $display("FAIL best_run%0d got %h/%b want %h/%b", i, bus.rt_bcd, bus.valid, e.rt, e.valid);
            end
`ifdef F1_BEST_TIME_EN
            want_best = best_tab[i];
`else
            want_best = 16'h0000;
`endif
            checks++;
            if (bus.best_bcd !== want_best) begin
                errors++; $display("FAIL best_value%0d got %h want %h", i, bus.best_bcd, want_best);
            end
        end
    endtask

    task automatic test_saturation();
        bit ok;
        logic [15:0] want_best;
`ifdef F1_BEST_TIME_EN
        want_best = 16'h0180;
`else
        want_best = 16'h0000;
`endif
        exp_q.push_back('{rt: 16'h9999, valid: 1'b1, jump: 1'b0});
        do_run(0, ok);
        e = exp_q.pop_front();
        checks++;
        if (!ok) begin errors++; $display("FAIL sat_timeout no result"); end
        checks++;
        if (bus.rt_bcd !== e.rt || bus.valid !== e.valid) begin
            errors++; $display("FAIL sat_result got %h/%b want %h/%b", bus.rt_bcd, bus.valid, e.rt, e.valid);
        end
        bus.react = 1'b1;
        step(10);
        checks++;
        if (bus.rt_bcd !== 16'h9999 || bus.valid !== 1'b1) begin
            errors++; $display("FAIL sat_late_press got %h/%b want 9999/1", bus.rt_bcd, bus.valid);
        end
        bus.react = 1'b0;
        step(4);
        checks++;
        if (bus.best_bcd !== want_best) begin
            errors++; $display("FAIL sat_best got %h want %h", bus.best_bcd, want_best);
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst        = 1'b1;
        bus.lights = 8'h00;
        bus.react  = 1'b0;
        step(2);
        rst = 1'b0;
        step(2);
        test_reset();
        test_normal();
        test_jump_start();
        test_abort_held();
        test_best_time();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/f1_reaction_timer.md
Name: f1_reaction_timer

Overview:
- Downstream consumer of the F1 start-light sequencer's 8-bit light bus.
- Watches the lights fill to 8'hFF, then times from "lights out" (8'hFF -> 8'h00) to the driver's button press.
- Reports the reaction time as 4-digit BCD milliseconds, and flags a jump start if the button is pressed before lights out.
- Sits between the light FSM and the 7-segment display driver.

Parameters:
- CLK_PER_MS, 1000: clock cycles per millisecond tick. Bench uses 4.
- SYNC_STAGES, 2: depth of the button synchroniser; minimum 2.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- lights  in  8  light bus from the start-light FSM
- react  in  1  raw driver button, asynchronous
- rt_bcd  out  16  reaction time in ms, BCD {thousands, hundreds, tens, units}
- valid  out  1  high while a measured result is held (DONE)
- jump_start  out  1  high while in FAULT
- timing  out  1  high while the ms counter runs
- best_bcd  out  16  best (minimum) valid time; see Optional Feature

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; rt_bcd=16'h0000; valid=0; jump_start=0; timing=0; best_bcd=16'h0000.
  - Prescaler=0; synchroniser flops cleared.
- react path:
  - Passes through a SYNC_STAGES flop chain, then a rising-edge detector.
  - press_pulse is a 1-cycle pulse, SYNC_STAGES+1 cycles after react rises.
  - A held button produces exactly one pulse.
- State machine, with transitions evaluated on each clk rising edge:
  - IDLE: if lights!=0, go to ARMED.
  - ARMED (sequence building):
    - press_pulse -> FAULT.
    - else lights==8'hFF -> FULL.
    - else lights==0 (sequence aborted) -> IDLE.
  - FULL:
    - press_pulse -> FAULT.
    - else lights==0 -> TIMING; clear prescaler and rt_bcd on this same edge.
    - Any other nonzero value stays in FULL.
  - TIMING (timing=1):
    - Prescaler counts 0..CLK_PER_MS-1; on wrap, rt_bcd increments by 1 ms.
    - BCD carries ripple units->tens->hundreds->thousands, each digit in 0..9.
    - press_pulse -> DONE with rt_bcd frozen. If the press and a ms wrap coincide, the increment is applied first.
    - rt_bcd reaching 16'h9999 -> DONE, holding 9999 (saturate, no wrap).
    - lights!=0 while timing (new sequence) -> ARMED; result discarded, valid stays 0.
  - DONE (valid=1): rt_bcd held; on lights!=0 -> ARMED.
  - FAULT (jump_start=1): rt_bcd=16'h0000; on lights!=0 -> ARMED.
    - A FAULT entered while lights are already nonzero leaves on the next edge where lights!=0 is sampled after lights have first returned to 0.
- Entering ARMED clears valid, jump_start and rt_bcd.
- Outputs are registered; valid, jump_start and timing are decoded from registered state.
- Reset mid-operation returns immediately to IDLE with all outputs at reset values.
- Latency: lights out to timing=1 is 1 cycle; press_pulse to valid=1 is 1 cycle.

Optional Feature:
- Macro: F1_BEST_TIME_EN.
- Defined:
  - On every DONE entry that was not caused by saturation, best_bcd <= rt_bcd if best_bcd==0 or rt_bcd < best_bcd.
  - Comparison is numeric on BCD digits, most-significant digit first.
  - best_bcd is cleared only by rst.
- Undefined: best_bcd is tied to 16'h0000 and no comparison logic is built.

Test Plan:
1. Reset mid-TIMING.
   - Stimulus: CLK_PER_MS=4; lights 01,03,...,FF then 00; assert rst after 10 cycles.
   - Required: all outputs 0, state IDLE in the same cycle.
2. Normal reaction.
   - Stimulus: lights FF -> 00; react rises exactly 4*123 cycles after timing rises, minus synchroniser latency.
   - Required: rt_bcd=16'h0123, valid=1, timing=0; value held until lights go to 01.
3. Jump start.
   - Stimulus: react pulse while lights=8'h1F.
   - Required: jump_start=1, rt_bcd=0, valid=0; lights 00 then 01 -> ARMED with jump_start=0.
4. Saturation.
   - Stimulus: no press after lights out for more than 4*9999 cycles.
   - Required: rt_bcd=16'h9999, valid=1; a later press has no effect.
5. Aborted sequence and held button.
   - Stimulus: lights 07 -> 00 before reaching FF.
   - Required: back to IDLE, no valid.
   - Stimulus: react held high across lights out.
   - Required: no press_pulse and timing continues (the held button's edge occurred earlier, so FAULT was already taken if it rose during ARMED).
6. Best time (F1_BEST_TIME_EN defined).
   - Stimulus: runs of 0250, 0180, 0300 ms.
   - Required: best_bcd=16'h0250, then 16'h0180, then stays 16'h0180.
